// File: rtl/in_vitro_scan_pkg.sv
// in_vitro_scan_pkg: shared scanner state encoding and channel-index sizing
package in_vitro_scan_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, EMIT} state_t;
   localparam int NUM_CH_DEF = 12;
   localparam int CH_W = 4;
endpackage

// File: rtl/scan_accumulator.sv
// scan_accumulator: per-channel sample sum with count and shifted average
// ports: clk, rst (async), clear, add, data in; last (next add completes the set), avg_next (average including data)
module scan_accumulator #(
   parameter int SAMPLE_W = 12,
   parameter int AVG_LOG2 = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                add,
   input  logic [SAMPLE_W-1:0] data,
   output logic                last,
   output logic [SAMPLE_W-1:0] avg_next
);
   localparam int ACC_W = SAMPLE_W + AVG_LOG2;
   localparam int N = 1 << AVG_LOG2;
   logic [ACC_W-1:0] acc, sum;
   logic [AVG_LOG2:0] cnt;
   assign sum = acc + ACC_W'(data);
   // average is taken from the sum including the transfer in flight so the result registers on the same edge
   assign avg_next = SAMPLE_W'(sum >> AVG_LOG2);
   assign last = int'(cnt) == N - 1;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc <= '0;
         cnt <= '0;
      end else if (clear) begin
         acc <= '0;
         cnt <= '0;
      end else if (add) begin
         acc <= sum;
         cnt <= cnt + 1'b1;
      end
endmodule

// File: rtl/in_vitro_readout_scanner.sv
// in_vitro_readout_scanner: per-channel mux settle, averaged ADC sampling and thresholded result stream
// ports: clk, rst (async); start/threshold/busy/done scan control; ch_sel mux select;
//        adc_req/adc_ack/adc_data sample handshake; out_valid/out_ready/out_ch/out_value/out_over result stream
module in_vitro_readout_scanner
   import in_vitro_scan_pkg::*;
#(
   parameter int NUM_CH     = NUM_CH_DEF,
   parameter int SAMPLE_W   = 12,
   parameter int AVG_LOG2   = 2,
   parameter int SETTLE_CYC = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [SAMPLE_W-1:0] threshold,
   output logic                busy,
   output logic                done,
   output logic [CH_W-1:0]     ch_sel,
   output logic                adc_req,
   input  logic                adc_ack,
   input  logic [SAMPLE_W-1:0] adc_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CH_W-1:0]     out_ch,
   output logic [SAMPLE_W-1:0] out_value,
   output logic                out_over
);
   state_t state;
   logic [7:0] settle_cnt;
   logic [SAMPLE_W-1:0] thr;
   logic xfer, accept, acc_last;
   logic [SAMPLE_W-1:0] avg_next;
   assign xfer = adc_req && adc_ack;
   assign accept = out_valid && out_ready;
   scan_accumulator #(.SAMPLE_W(SAMPLE_W), .AVG_LOG2(AVG_LOG2)) u_acc (
      .clk(clk),
      .rst(rst),
      .clear((state == IDLE && start) || accept),
      .add(xfer),
      .data(adc_data),
      .last(acc_last),
      .avg_next(avg_next)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         settle_cnt <= '0;
         thr <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         ch_sel <= '0;
         adc_req <= 1'b0;
         out_valid <= 1'b0;
         out_ch <= '0;
         out_value <= '0;
         out_over <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  thr <= threshold;
                  ch_sel <= '0;
                  busy <= 1'b1;
                  settle_cnt <= '0;
                  state <= SETTLE;
               end
            SETTLE:
               if (settle_cnt == 8'(SETTLE_CYC - 1)) begin
                  adc_req <= 1'b1;
                  state <= SAMPLE;
               end else
                  settle_cnt <= settle_cnt + 8'd1;
            SAMPLE:
               if (xfer && acc_last) begin
                  adc_req <= 1'b0;
                  out_valid <= 1'b1;
                  out_ch <= ch_sel;
                  out_value <= avg_next;
                  out_over <= avg_next >= thr;
                  state <= EMIT;
               end
            EMIT:
               if (out_ready) begin
                  out_valid <= 1'b0;
                  settle_cnt <= '0;
                  if (ch_sel == CH_W'(NUM_CH - 1)) begin
                     busy <= 1'b0;
                     done <= 1'b1;
                     state <= IDLE;
                  end else begin
                     ch_sel <= ch_sel + CH_W'(1);
                     state <= SETTLE;
                  end
               end
         endcase
      end
endmodule

// File: tb/tb_in_vitro_readout_scanner.sv
// tb_in_vitro_readout_scanner: scoreboard bench for the readout scanner
module tb_in_vitro_readout_scanner;
   localparam int NCH = 12;
   localparam int SW = 12;
   logic clk = 1'b0;
   logic rst, start, adc_ack, out_ready;
   logic [SW-1:0] threshold, adc_data, out_value;
   logic busy, done, adc_req, out_valid, out_over;
   logic [3:0] ch_sel, out_ch;
   always #5 clk = ~clk;
   in_vitro_readout_scanner dut (
      .clk(clk), .rst(rst), .start(start), .threshold(threshold),
      .busy(busy), .done(done), .ch_sel(ch_sel),
      .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
      .out_value(out_value), .out_over(out_over)
   );
   typedef struct {int ch; int value; bit over;} res_t;
   res_t exp_q[$];
   int checks = 0, errors = 0, cyc = 0;
   int acc_cyc[$];
   bit done_exp = 1'b0;
   int samp_q[$];
   int def_data = 0, ack_delay = 0, wait_cnt = 0, xfers = 0, drop_err = 0;
   bit spurious = 1'b0, xfer_prev = 1'b0, req_prev = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(string name, int act, int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask
   // ADC model: ack tied high when ack_delay==0, else ack after ack_delay waiting cycles
   always @(negedge clk) begin
      if (ack_delay > 0 && req_prev && !xfer_prev && !adc_req) drop_err++;
      if (xfer_prev) begin
         xfers++;
         if (samp_q.size() > 0) void'(samp_q.pop_front());
         wait_cnt = 0;
      end
      req_prev = adc_req;
      adc_data = (samp_q.size() > 0) ? SW'(samp_q[0]) : SW'(def_data);
      if (ack_delay == 0) adc_ack = 1'b1;
      else if (adc_req) begin
         adc_ack = wait_cnt >= ack_delay;
         wait_cnt++;
      end else begin
         adc_ack = spurious;
         wait_cnt = 0;
      end
      xfer_prev = adc_req && adc_ack;
   end
   // monitor: pops the scoreboard on every accepted result and checks the done pulse
   always @(negedge clk) begin
      res_t e;
      #1;
      if (rst) done_exp = 1'b0;
      else begin
         if (done || done_exp) chk("done_pulse", int'(done), int'(done_exp));
         if (done_exp) chk("busy_at_done", int'(busy), 0);
         done_exp = 1'b0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result: got ch %0d value 0x%0h, required none", out_ch, out_value);
            end else begin
               e = exp_q.pop_front();
               chk("out_ch", int'(out_ch), e.ch);
               chk("out_value", int'(out_value), e.value);
               chk("out_over", int'(out_over), int'(e.over));
               done_exp = e.ch == NCH - 1;
            end
            acc_cyc.push_back(cyc);
         end
      end
   end
   task automatic push_exp(int ch, int v, int thr);
      res_t r;
      r.ch = ch;
      r.value = v;
      r.over = v >= thr;
      exp_q.push_back(r);
   endtask
   task automatic start_scan(int thr);
      @(negedge clk);
      threshold = SW'(thr);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", int'(busy), 1);
      chk("ch_sel_after_start", int'(ch_sel), 0);
      repeat (7) @(negedge clk);
      chk("adc_req_in_settle", int'(adc_req), 0);
      @(negedge clk);
      chk("adc_req_first", int'(adc_req), 1);
   endtask
   task automatic wait_done(int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         errors++;
         $display("FAIL done_timeout: got no done within %0d cycles, required done", budget);
      end
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
   endtask
   task automatic chk_reset_outputs(string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_ch_sel"}, int'(ch_sel), 0);
      chk({tag, "_adc_req"}, int'(adc_req), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_out_ch"}, int'(out_ch), 0);
      chk({tag, "_out_value"}, int'(out_value), 0);
      chk({tag, "_out_over"}, int'(out_over), 0);
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1, "timeout");
   end
   initial begin
      int n;
      rst = 1'b1;
      start = 1'b0;
      threshold = '0;
      out_ready = 1'b1;
      adc_ack = 1'b0;
      adc_data = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      // full scan, ack tied high, 13-cycle result cadence
      acc_cyc.delete();
      def_data = 'h100;
      for (int i = 0; i < NCH; i++) push_exp(i, 'h100, 'hFF);
      start_scan('hFF);
      wait_done(400);
      chk("result_count", acc_cyc.size(), NCH);
      for (int i = 1; i < acc_cyc.size(); i++) chk("result_gap", acc_cyc[i] - acc_cyc[i-1], 13);
      // truncation on channel 0, full-scale elsewhere
      samp_q = '{1, 2, 2, 2};
      def_data = 'hFFF;
      push_exp(0, 1, 'h100);
      for (int i = 1; i < NCH; i++) push_exp(i, 'hFFF, 'h100);
      start_scan('h100);
      wait_done(400);
      // threshold boundary plus ignored start while busy
      samp_q = '{'h100, 'h100, 'h100, 'h100, 'hFF, 'hFF, 'hFF, 'hFF};
      def_data = 'h100;
      push_exp(0, 'h100, 'h100);
      push_exp(1, 'hFF, 'h100);
      for (int i = 2; i < NCH; i++) push_exp(i, 'h100, 'h100);
      start_scan('h100);
      @(negedge clk);
      threshold = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_held", int'(busy), 1);
      wait_done(400);
      // backpressure on channel 0
      def_data = 'h321;
      out_ready = 1'b0;
      for (int i = 0; i < NCH; i++) push_exp(i, 'h321, 'h400);
      start_scan('h400);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_out_ch", int'(out_ch), 0);
         chk("bp_out_value", int'(out_value), 'h321);
         chk("bp_adc_req", int'(adc_req), 0);
         chk("bp_ch_sel", int'(ch_sel), 0);
      end
      out_ready = 1'b1;
      wait_done(400);
      // slow ack with spurious acks outside SAMPLE
      ack_delay = 3;
      spurious = 1'b1;
      xfers = 0;
      drop_err = 0;
      def_data = 'hAB;
      for (int i = 0; i < NCH; i++) push_exp(i, 'hAB, 'hAC);
      start_scan('hAC);
      wait_done(1000);
      chk("xfer_count", xfers, 4 * NCH);
      chk("req_dropped", drop_err, 0);
      ack_delay = 0;
      spurious = 1'b0;
      // reset in SAMPLE of channel 5
      def_data = 'h100;
      for (int i = 0; i < 5; i++) push_exp(i, 'h100, 'hFF);
      start_scan('hFF);
      n = 0;
      while (!(ch_sel == 4'd5 && adc_req) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reached_ch5_sample", int'(ch_sel), 5);
      rst = 1'b1;
      #1;
      chk_reset_outputs("midscan_reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("post_reset_busy", int'(busy), 0);
      chk("post_reset_queue", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/in_vitro_readout_scanner.md
# in_vitro_readout_scanner

Sequencing readout controller for the 12-channel in-vitro diagnostics assay array. It consumes the fluorescence detector outputs fl1..fl12, one channel at a time. For each channel it:
- steers the shared analog mux,
- waits for settling,
- takes 2^AVG_LOG2 ADC samples over a req/ack handshake,
- emits one averaged, threshold-flagged result per channel on a valid/ready stream.

It sits between the detector bank and the host/result logic.

## Interface
Parameters:
- NUM_CH, 12, number of detector channels scanned (1..16)
- SAMPLE_W, 12, ADC sample width in bits
- AVG_LOG2, 2, log2 of samples averaged per channel (0..4)
- SETTLE_CYC, 8, mux settling cycles per channel (1..255)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle scan request; ignored while busy
- threshold  in  SAMPLE_W  positive-detection level; captured on accepted start
- busy  out  1  high from accepted start until scan completes
- done  out  1  one-cycle pulse after last channel's result is accepted
- ch_sel  out  4  analog mux select (current channel index)
- adc_req  out  1  sample request
- adc_ack  in  1  sample valid; transfer when adc_req && adc_ack
- adc_data  in  SAMPLE_W  sample, valid with adc_ack
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_ch  out  4  channel index of result
- out_value  out  SAMPLE_W  averaged sample
- out_over  out  1  out_value >= captured threshold

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, EMIT.
- IDLE: busy=0. On start=1 the scanner:
  - captures threshold;
  - sets ch_sel=0, clears the accumulator and sample count;
  - moves to SETTLE.
- SETTLE: the settle counter counts SETTLE_CYC cycles, then the FSM moves to SAMPLE.
- SAMPLE: adc_req=1.
  - Each rising edge with adc_req && adc_ack adds adc_data to the accumulator and increments the sample count.
  - After the 2^AVG_LOG2-th transfer, the FSM moves to EMIT.
  - adc_req may stay high across back-to-back transfers.
- EMIT: out_valid=1.
  - out_value = accumulator >> AVG_LOG2, truncating.
  - out_over = (out_value >= threshold), unsigned compare.
  - out_ch = ch_sel.
- On out_valid && out_ready:
  - if ch_sel == NUM_CH-1: go to IDLE and pulse done;
  - otherwise: ch_sel+1, clear accumulator and count, go to SETTLE.
- Accumulator width is SAMPLE_W+AVG_LOG2; it never overflows.
- start while busy: no effect, threshold not recaptured.
- adc_ack while adc_req=0: ignored.
- Reset, including mid-scan: all state cleared, FSM to IDLE, no done pulse, no partial result emitted.

## Timing
- Reset values: busy=0, done=0, ch_sel=0, adc_req=0, out_valid=0, out_ch=0, out_value=0, out_over=0.
- All outputs are registered.
- start sampled at edge T: busy=1 and ch_sel=0 from T+1; adc_req first high at T+1+SETTLE_CYC.
- With adc_ack tied high:
  - 2^AVG_LOG2 SAMPLE cycles, then out_valid high for 1 cycle if out_ready=1;
  - per-channel cost SETTLE_CYC + 2^AVG_LOG2 + 1 cycles.
- Result payload is held stable while out_valid && !out_ready. No ADC requests are issued during backpressure.
- ch_sel changes only on the edge leaving EMIT.
- done is high exactly one cycle, the cycle after the final accept edge; busy falls in that same cycle.
- A new start may be accepted in the cycle done is high.

## Structure
- Shared package in_vitro_scan_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, EMIT);
  - default NUM_CH=12;
  - CH_W=4.
- One natural sub-module: scan_accumulator (clear, add, count, done flag, shifted average). The FSM and handshakes stay in the top.

## Test plan
- Defaults, ack tied high, adc_data=0x100, threshold=0x0FF, out_ready=1 -> 12 results:
  - out_ch 0..11, value 0x100, over=1;
  - results 13 cycles apart;
  - done one cycle after the 12th accept.
- Sample sequence 1,2,2,2 on channel 0 -> out_value=1 (truncation). All samples 0xFFF -> out_value=0xFFF, no overflow.
- threshold=0x100, value 0x100 -> over=1; value 0x0FF -> over=0.
- out_ready low 5 cycles in EMIT -> out_valid, out_ch, out_value stable; adc_req=0; ch_sel unchanged.
- adc_ack delayed 3 cycles per sample -> adc_req held until each ack, exactly 4 transfers counted. Spurious ack in SETTLE -> ignored.
- rst pulsed mid-SAMPLE on channel 5 -> all outputs return to reset values, no done. start pulsed while busy -> ignored, threshold unchanged.
